// File: rtl/program_loader_if.sv
// Byte-stream handshake, RAM write port and CPU status lines for program_loader.
// The loader uses the master modport; the stream source and RAM side use slave.
interface program_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] address;
  logic [15:0]       data;
  logic              data_oe;
  logic              ram_en;
  logic              rw;
  logic              halt;
  logic              done;
  logic              error;

  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, address, data, data_oe, ram_en, rw, halt, done, error
  );

  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, address, data, data_oe, ram_en, rw, halt, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader for the BatAmateur CPU: receives a length-prefixed, XOR-checksummed
// byte stream, writes the 16-bit words into RAM and releases HALT on success.
module program_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 4096,
  parameter int                TIMEOUT   = 65535
) (
  input logic               clk,
  input logic               rst_n,
  program_loader_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO,
    S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t          state, state_next;
  logic [15:0]     len;
  logic [15:0]     idx;
  logic [7:0]      hi_buf;
  logic [7:0]      chk;
  logic [TW-1:0]   tcnt;

  logic            accept;
  logic            start_ok;
  logic            timeout_hit;
  logic [15:0]     len_word;
  logic [15:0]     idx_inc;

  assign bus.byte_ready = state inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHECK};
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign start_ok       = bus.start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign timeout_hit    = bus.byte_ready && !accept && (tcnt == TW'(TIMEOUT - 1));
  assign len_word       = {len[15:8], bus.byte_in};
  assign idx_inc        = idx + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_word == 16'd0)                  state_next = S_CHECK;
          else if (len_word > 16'(MAX_WORDS))     state_next = S_ERR;
          else                                    state_next = S_DAT_HI;
        end
      end
      S_DAT_HI: if (accept) state_next = S_DAT_LO;
      S_DAT_LO: if (accept) state_next = S_WRITE;
      S_WRITE:  state_next = (idx_inc == len) ? S_CHECK : S_DAT_HI;
      S_CHECK:  if (accept) state_next = (bus.byte_in == chk) ? S_DONE : S_ERR;
      default:  state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_ERR;
  end

  // Idle counter only runs while a byte is awaited, so it stays frozen in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len    <= '0;
      idx    <= '0;
      hi_buf <= '0;
      chk    <= '0;
      tcnt   <= '0;
    end else begin
      if (start_ok) begin
        chk  <= '0;
        idx  <= '0;
        tcnt <= '0;
      end else if (accept) begin
        chk  <= chk ^ bus.byte_in;
        tcnt <= '0;
      end else if (bus.byte_ready) begin
        tcnt <= tcnt + TW'(1);
      end
      if (accept && state == S_LEN_HI) len[15:8] <= bus.byte_in;
      if (accept && state == S_LEN_LO) len[7:0]  <= bus.byte_in;
      if (accept && state == S_DAT_HI) hi_buf    <= bus.byte_in;
      if (state == S_WRITE)            idx       <= idx_inc;
    end
  end

  // Strobes are registered and zero outside WRITE because the top ORs them with the CPU bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_en  <= 1'b0;
      bus.rw      <= 1'b0;
      bus.data_oe <= 1'b0;
      bus.address <= '0;
      bus.data    <= '0;
      bus.halt    <= 1'b0;
      bus.done    <= 1'b0;
      bus.error   <= 1'b0;
    end else begin
      if (state_next == S_WRITE) begin
        bus.ram_en  <= 1'b1;
        bus.rw      <= 1'b1;
        bus.data_oe <= 1'b1;
        bus.address <= BASE_ADDR + ADDR_W'(idx);
        bus.data    <= {hi_buf, bus.byte_in};
      end else begin
        bus.ram_en  <= 1'b0;
        bus.rw      <= 1'b0;
        bus.data_oe <= 1'b0;
        bus.address <= '0;
        bus.data    <= '0;
      end
      bus.halt  <= !(state_next inside {S_IDLE, S_DONE});
      bus.done  <= (state_next == S_DONE);
      bus.error <= (state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (base 0x0000 and 0xFFFF) share
// one stream; RAM writes are logged on the falling edge and checked per load.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;
  int strobe_bad = 0;
  int halt_bad = 0;
  logic prev_done = 1'b0;
  logic prev_halt = 1'b0;

  logic [15:0] addr_a[$];
  logic [15:0] data_a[$];
  logic [15:0] addr_b[$];
  logic [15:0] data_b[$];
  logic [7:0]  stream[$];

  program_loader_if #(.ADDR_W(16)) if_a ();
  program_loader_if #(.ADDR_W(16)) if_b ();

  assign if_a.start      = start;
  assign if_a.byte_in    = byte_in;
  assign if_a.byte_valid = byte_valid;
  assign if_b.start      = start;
  assign if_b.byte_in    = byte_in;
  assign if_b.byte_valid = byte_valid;

  program_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .MAX_WORDS(4096), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.master)
  );
  program_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF), .MAX_WORDS(4096), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.master)
  );

  always #5 clk = ~clk;

  // Log every write cycle and flag strobes or HALT/DONE edges that misbehave.
  always @(negedge clk) begin
    if (if_a.ram_en) begin
      addr_a.push_back(if_a.address);
      data_a.push_back(if_a.data);
      if (!if_a.rw || !if_a.data_oe) strobe_bad++;
    end else if (if_a.address != 0 || if_a.data != 0 || if_a.rw || if_a.data_oe) begin
      strobe_bad++;
    end
    if (if_b.ram_en) begin
      addr_b.push_back(if_b.address);
      data_b.push_back(if_b.data);
      if (!if_b.rw || !if_b.data_oe) strobe_bad++;
    end else if (if_b.address != 0 || if_b.data != 0 || if_b.rw || if_b.data_oe) begin
      strobe_bad++;
    end
    if (if_a.done && !prev_done && (if_a.halt || !prev_halt)) halt_bad++;
    prev_done = if_a.done;
    prev_halt = if_a.halt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    waited = 0;
    while (!if_a.byte_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!if_a.byte_ready) begin
      checkOutput("ready_wait", 32'd0, 32'd1);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 byte_valid = 1'b0;
    end
  endtask

  task automatic playStream(input int max_gap);
    foreach (stream[i]) applyStimulus(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic pulseStart;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks the two expected words of the reference image on both instances.
  task automatic checkWrites(input string tag, input int base_a, input int base_b);
    checkOutput({tag, "_cnt_a"}, 32'(addr_a.size() - base_a), 32'd2);
    checkOutput({tag, "_cnt_b"}, 32'(addr_b.size() - base_b), 32'd2);
    if (addr_a.size() >= base_a + 2) begin
      checkOutput({tag, "_addr0"}, {16'h0, addr_a[base_a]},     32'h0000);
      checkOutput({tag, "_data0"}, {16'h0, data_a[base_a]},     32'h1234);
      checkOutput({tag, "_addr1"}, {16'h0, addr_a[base_a + 1]}, 32'h0001);
      checkOutput({tag, "_data1"}, {16'h0, data_a[base_a + 1]}, 32'hABCD);
    end
    if (addr_b.size() >= base_b + 2) begin
      checkOutput({tag, "_b_addr0"}, {16'h0, addr_b[base_b]},     32'hFFFF);
      checkOutput({tag, "_b_addr1"}, {16'h0, addr_b[base_b + 1]}, 32'h0000);
      checkOutput({tag, "_b_data1"}, {16'h0, data_b[base_b + 1]}, 32'hABCD);
    end
  endtask

  initial begin
    int ba, bb;
    repeat (3) @(negedge clk);
    checkOutput("rst_halt",  {31'h0, if_a.halt},       32'd0);
    checkOutput("rst_ready", {31'h0, if_a.byte_ready}, 32'd0);
    checkOutput("rst_flags", {30'h0, if_a.done, if_a.error}, 32'd0);
    rst_n = 1'b1;

    // Reference image; checksum 00^02^12^34^AB^CD = 0x42.
    $display("[TB] good image");
    ba = addr_a.size(); bb = addr_b.size();
    pulseStart();
    checkOutput("t1_halt_on", {31'h0, if_a.halt}, 32'd1);
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    playStream(0);
    @(negedge clk);
    checkWrites("t1", ba, bb);
    checkOutput("t1_done",  {31'h0, if_a.done},  32'd1);
    checkOutput("t1_halt",  {31'h0, if_a.halt},  32'd0);
    checkOutput("t1_error", {31'h0, if_a.error}, 32'd0);
    checkOutput("t1_ready", {31'h0, if_a.byte_ready}, 32'd0);

    $display("[TB] bad checksum");
    ba = addr_a.size(); bb = addr_b.size();
    pulseStart();
    checkOutput("t2_done_clr", {31'h0, if_a.done}, 32'd0);
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    playStream(0);
    @(negedge clk);
    checkWrites("t2", ba, bb);
    checkOutput("t2_error", {31'h0, if_a.error}, 32'd1);
    checkOutput("t2_halt",  {31'h0, if_a.halt},  32'd1);
    checkOutput("t2_done",  {31'h0, if_a.done},  32'd0);

    $display("[TB] empty image and oversize length");
    ba = addr_a.size();
    pulseStart();
    checkOutput("t3_err_clr", {31'h0, if_a.error}, 32'd0);
    stream = '{8'h00, 8'h00, 8'h00};
    playStream(0);
    @(negedge clk);
    checkOutput("t3_nowrite", 32'(addr_a.size() - ba), 32'd0);
    checkOutput("t3_done",    {31'h0, if_a.done}, 32'd1);
    pulseStart();
    stream = '{8'h10, 8'h01};
    playStream(0);
    @(negedge clk);
    checkOutput("t3_big_err",   {31'h0, if_a.error},      32'd1);
    checkOutput("t3_big_ready", {31'h0, if_a.byte_ready}, 32'd0);
    checkOutput("t3_big_nowr",  32'(addr_a.size() - ba),  32'd0);

    $display("[TB] gappy stream and idle timeout");
    ba = addr_a.size(); bb = addr_b.size();
    pulseStart();
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    playStream(6);
    @(negedge clk);
    checkWrites("t4", ba, bb);
    checkOutput("t4_done", {31'h0, if_a.done}, 32'd1);
    pulseStart();
    applyStimulus(8'h00, 0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_to_15", {31'h0, if_a.error}, 32'd0);
    @(negedge clk);
    checkOutput("t4_to_16", {31'h0, if_a.error}, 32'd1);

    $display("[TB] reset mid-load, then reload with stray START");
    ba = addr_a.size(); bb = addr_b.size();
    pulseStart();
    stream = '{8'h00, 8'h02, 8'h12, 8'h34};
    playStream(0);
    @(posedge clk);
    #1;
    checkOutput("t6_one_write", 32'(addr_a.size() - ba), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_halt",  {31'h0, if_a.halt},       32'd0);
    checkOutput("t6_rst_ready", {31'h0, if_a.byte_ready}, 32'd0);
    checkOutput("t6_rst_strb",  {31'h0, if_a.ram_en},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ba = addr_a.size(); bb = addr_b.size();
    pulseStart();
    stream = '{8'h00, 8'h02, 8'h12};
    playStream(0);
    pulseStart();
    stream = '{8'h34, 8'hAB, 8'hCD, 8'h42};
    playStream(0);
    @(negedge clk);
    checkWrites("t6", ba, bb);
    checkOutput("t6_done", {31'h0, if_a.done}, 32'd1);

    checkOutput("strobes_idle_zero", 32'(strobe_bad), 32'd0);
    checkOutput("halt_falls_with_done", 32'(halt_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
